// File: rtl/sim_test_monitor.sv
// End-of-test detector on the regfile write port: shadows x3/x26/x27 and
// latches a pass/fail/timeout verdict that holds until reset.
module sim_test_monitor #(
    parameter int REG_ADDR_W     = 5,
    parameter int DATA_W         = 32,
    parameter int START_DELAY    = 5,
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [DATA_W-1:0]     fail_testnum_o,
    output logic [DATA_W-1:0]     cycle_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic [DATA_W-1:0] x3_q, x3_d, x26_q, x26_d, x27_q, x27_d;
    logic              done_q, done_d, pass_q, pass_d, to_q, to_d;
    logic [DATA_W-1:0] tn_q, tn_d;
    logic              active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        x3_d    = x3_q;
        x26_d   = x26_q;
        x27_d   = x27_q;
        done_d  = done_q;
        pass_d  = pass_q;
        to_d    = to_q;
        tn_d    = tn_q;
        active  = (state_q != DONE);

        if (active) begin
            cnt_d = cnt_q + 1'b1;
            if (we_i) begin
                if (waddr_i == REG_ADDR_W'(3))  x3_d  = wdata_i;
                if (waddr_i == REG_ADDR_W'(26)) x26_d = wdata_i;
                if (waddr_i == REG_ADDR_W'(27)) x27_d = wdata_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (cnt_q == START_LAST) state_d = RUN;
            end
            RUN: begin
                if (x26_q == DATA_W'(1)) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                // x26 is not re-checked here: once draining, the verdict always lands
                drn_d = drn_q + 1'b1;
                if (drn_q == DRN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (x27_q == DATA_W'(1));
                    tn_d    = x3_q;
                end
            end
            default: ;
        endcase

        // Timeout overrides whatever the state logic decided this cycle
        if (active && (cnt_q == TO_LAST)) begin
            state_d = DONE;
            done_d  = 1'b1;
            to_d    = 1'b1;
            pass_d  = 1'b0;
            tn_d    = x3_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            x3_q    <= '0;
            x26_q   <= '0;
            x27_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            tn_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            x3_q    <= x3_d;
            x26_q   <= x26_d;
            x27_q   <= x27_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
            tn_q    <= tn_d;
        end
    end

    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign timeout_o      = to_q;
    assign fail_testnum_o = tn_q;
    assign cycle_cnt_o    = DATA_W'(cnt_q);

endmodule

// File: tb/tb_sim_test_monitor.sv
// Bench for sim_test_monitor: directed table, randomized schedules against a
// write-history model, and reset-in-drain sequence.
module tb_sim_test_monitor;

    localparam int S  = 5;
    localparam int DR = 5;
    localparam int T  = 5000;

    logic        clk, rst, we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        done_o, pass_o, timeout_o;
    logic [31:0] fail_testnum_o, cycle_cnt_o;

    sim_test_monitor #(
        .REG_ADDR_W(5), .DATA_W(32), .START_DELAY(S),
        .DRAIN_CYCLES(DR), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_testnum_o(fail_testnum_o), .cycle_cnt_o(cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          nw;
        wr_t         w0, w1, w2, w3;
        int          exp_done;
        logic        exp_pass;
        logic        exp_to;
        logic [31:0] exp_tn;
    } vec_t;

    wr_t  sched[$];
    vec_t vecs[8];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_id = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL case%0d %s: got %0d expected %0d", cur_id, nm, act, exp);
        end
    endtask

    function automatic wr_t mkw(input int c, input logic we, input int a, input int d);
        wr_t w;
        w.cyc = c; w.we = we; w.addr = 5'(a); w.data = 32'(d);
        return w;
    endfunction

    task automatic wv(input int v, input int c, input logic we, input int a, input int d);
        case (vecs[v].nw)
            0: vecs[v].w0 = mkw(c, we, a, d);
            1: vecs[v].w1 = mkw(c, we, a, d);
            2: vecs[v].w2 = mkw(c, we, a, d);
            default: vecs[v].w3 = mkw(c, we, a, d);
        endcase
        vecs[v].nw++;
    endtask

    task automatic ev(input int v, input int d, input logic p, input logic to, input int tn);
        vecs[v].exp_done = d; vecs[v].exp_pass = p;
        vecs[v].exp_to = to;  vecs[v].exp_tn = 32'(tn);
    endtask

    // Value held by register r after edge k: the latest enabled write at or before k
    function automatic logic [31:0] sh(input int r, input int k);
        logic [31:0] v = 0;
        int best = -1;
        foreach (sched[i])
            if (sched[i].we && sched[i].addr == 5'(r) && sched[i].cyc <= k && sched[i].cyc > best) begin
                best = sched[i].cyc;
                v = sched[i].data;
            end
        return v;
    endfunction

    task automatic model(output int d, output logic p, output logic to, output logic [31:0] tn);
        int e = -1;
        for (int k = S; k <= T; k++)
            if (sh(26, k) == 32'd1) begin e = k; break; end
        if (e < 0 || e + 1 + DR >= T) begin
            d = T; to = 1'b1; p = 1'b0; tn = sh(3, T - 1);
        end else begin
            d = e + 1 + DR; to = 1'b0;
            p = (sh(27, d - 1) == 32'd1);
            tn = sh(3, d - 1);
        end
    endtask

    task automatic apply(input int k);
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        foreach (sched[i])
            if (sched[i].cyc == k) begin
                we_i = sched[i].we; waddr_i = sched[i].addr; wdata_i = sched[i].data;
            end
    endtask

    task automatic step(input int k);
        apply(k);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        rst = 1'b0;
        apply(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done_o}, 0);
        chk("rst_cnt", cycle_cnt_o, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_and_check(input int exp_done, input logic exp_pass,
                                 input logic exp_to, input logic [31:0] exp_tn);
        int first_done = -1;
        bit track_ok = 1'b1;
        reset_release();
        for (int k = 1; k <= T + 20; k++) begin
            step(k);
            if (first_done < 0 && done_o) begin
                first_done = k;
                chk("pass", {31'd0, pass_o}, {31'd0, exp_pass});
                chk("timeout", {31'd0, timeout_o}, {31'd0, exp_to});
                chk("testnum", fail_testnum_o, exp_tn);
                chk("cnt_at_done", cycle_cnt_o, 32'(exp_done));
            end
            if (first_done < 0 && cycle_cnt_o != 32'(k)) track_ok = 1'b0;
            if (first_done >= 0 && k >= first_done + 3) break;
        end
        chk("done_cycle", 32'(first_done), 32'(exp_done));
        chk("cnt_tracking", {31'd0, track_ok}, 1);
        chk("cnt_frozen", cycle_cnt_o, 32'(exp_done));
        chk("pass_held", {31'd0, pass_o}, {31'd0, exp_pass});
        chk("done_held", {31'd0, done_o}, 1);
    endtask

    initial begin
        int          md;
        logic        mp, mt;
        logic [31:0] mtn;

        rst = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        foreach (vecs[v]) vecs[v].nw = 0;

        wv(0, 10, 1, 3, 7);   wv(0, 20, 1, 27, 1);  wv(0, 21, 1, 26, 1);  ev(0, 27, 1, 0, 7);
        wv(1, 8, 1, 3, 12);   wv(1, 9, 1, 27, 0);   wv(1, 15, 1, 26, 1);  ev(1, 21, 0, 0, 12);
        wv(2, 6, 1, 3, 4);    wv(2, 10, 1, 26, 1);  wv(2, 12, 1, 27, 1);  ev(2, 16, 1, 0, 4);
        wv(3, 10, 1, 26, 1);  wv(3, 17, 1, 27, 1);                        ev(3, 16, 0, 0, 0);
        wv(4, 10, 1, 0, 1);   wv(4, 11, 1, 25, 1);  wv(4, 12, 1, 28, 1);
        wv(4, 13, 0, 26, 1);                                              ev(4, T, 0, 1, 0);
        wv(5, 2, 1, 26, 1);                                               ev(5, 11, 0, 0, 0);
        wv(6, 5, 1, 27, 1);   wv(6, 7, 1, 26, 1);   wv(6, 9, 1, 26, 0);   ev(6, 13, 1, 0, 0);
        wv(7, 100, 1, 27, 1); wv(7, 200, 1, 3, 9);  wv(7, 4994, 1, 26, 1); ev(7, T, 0, 1, 9);

        for (int v = 0; v < 8; v++) begin
            cur_id = v;
            sched.delete();
            if (vecs[v].nw > 0) sched.push_back(vecs[v].w0);
            if (vecs[v].nw > 1) sched.push_back(vecs[v].w1);
            if (vecs[v].nw > 2) sched.push_back(vecs[v].w2);
            if (vecs[v].nw > 3) sched.push_back(vecs[v].w3);
            run_and_check(vecs[v].exp_done, vecs[v].exp_pass, vecs[v].exp_to, vecs[v].exp_tn);
        end

        for (int r = 0; r < 8; r++) begin
            int c = 0;
            int nw = $urandom_range(2, 6);
            cur_id = 100 + r;
            sched.delete();
            for (int i = 0; i < nw; i++) begin
                int sel = $urandom_range(0, 9);
                int a;
                logic [31:0] d;
                c += $urandom_range(1, 12);
                a = (sel < 3) ? 3 : (sel < 6) ? 26 : (sel < 8) ? 27 : (sel == 8) ? 0 : $urandom_range(0, 31);
                d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1));
                sched.push_back(mkw(c, ($urandom_range(0, 7) != 0), a, int'(d)));
            end
            if (r < 6) sched.push_back(mkw(c + 3, 1'b1, 26, 1));
            model(md, mp, mt, mtn);
            run_and_check(md, mp, mt, mtn);
        end

        // Reset asserted mid-drain: outputs clear at once, shadows do not survive
        cur_id = 200;
        sched.delete();
        sched.push_back(mkw(6, 1'b1, 3, 5));
        sched.push_back(mkw(7, 1'b1, 27, 1));
        sched.push_back(mkw(8, 1'b1, 26, 1));
        reset_release();
        for (int k = 1; k <= 11; k++) step(k);
        rst = 1'b0;
        #1;
        chk("async_done", {31'd0, done_o}, 0);
        chk("async_pass", {31'd0, pass_o}, 0);
        chk("async_to", {31'd0, timeout_o}, 0);
        chk("async_tn", fail_testnum_o, 0);
        chk("async_cnt", cycle_cnt_o, 0);
        cur_id = 201;
        sched.delete();
        sched.push_back(mkw(40, 1'b1, 26, 1));
        run_and_check(46, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
